// File: rtl/seg_scan_if.sv
// Load port of the 7-segment scan controller: value + decimal points offered over valid/ready.
interface seg_scan_if;
    logic        load_valid;
    logic [15:0] load_data;
    logic [3:0]  load_dp;
    logic        load_ready;

    modport master (output load_valid, output load_data, output load_dp, input load_ready);
    modport slave  (input load_valid, input load_data, input load_dp, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller: double-buffered value, commits only at frame
// boundaries or while idle, blanks each digit slot briefly to avoid ghosting.
module seg_scan_ctrl #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       lz_blank,
    seg_scan_if.slave  load,
    output logic [7:0] seg,
    output logic [3:0] anode,
    output logic       frame_done
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] slot_reg, slot_next;
    logic [1:0]    digit_reg, digit_next;
    logic [15:0]   act_data_reg, pend_data_reg;
    logic [3:0]    act_dp_reg, pend_dp_reg;
    logic          pend_full_reg;
    logic [7:0]    seg_reg, seg_next;
    logic [3:0]    anode_reg, anode_next;
    logic [3:0]    lead_zero;
    logic [3:0]    cur_nib;
    logic          commit, accept;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            slot_reg  <= '0;
            digit_reg <= '0;
        end else begin
            state_reg <= state_next;
            slot_reg  <= slot_next;
            digit_reg <= digit_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg;
        digit_next = digit_reg;
        frame_done = 1'b0;
        case (state_reg)
            IDLE: begin
                slot_next  = '0;
                digit_next = '0;
                if (enable) state_next = BLANK;
            end
            BLANK: begin
                slot_next = slot_reg + 1'b1;
                if (slot_reg == BLANK_LAST) state_next = DRIVE;
            end
            DRIVE: begin
                if (slot_reg == SLOT_LAST) begin
                    slot_next  = '0;
                    digit_next = digit_reg + 2'd1;
                    state_next = BLANK;
                    frame_done = (digit_reg == 2'd3);
                end else begin
                    slot_next = slot_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Dropping enable aborts the slot immediately, whatever the state.
        if (!enable) begin
            state_next = IDLE;
            slot_next  = '0;
            digit_next = '0;
        end
    end

    // The pending buffer can only be written while empty, so commit and accept never coincide.
    assign commit          = pend_full_reg && (frame_done || state_reg == IDLE);
    assign accept          = load.load_valid && !pend_full_reg;
    assign load.load_ready = ~pend_full_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_data_reg <= '0;
            pend_dp_reg   <= '0;
            act_data_reg  <= '0;
            act_dp_reg    <= '0;
            pend_full_reg <= 1'b0;
        end else if (commit) begin
            act_data_reg  <= pend_data_reg;
            act_dp_reg    <= pend_dp_reg;
            pend_full_reg <= 1'b0;
        end else if (accept) begin
            pend_data_reg <= load.load_data;
            pend_dp_reg   <= load.load_dp;
            pend_full_reg <= 1'b1;
        end
    end

    // lead_zero[k]: nibbles k..3 of the active value are all zero.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lz
        assign lead_zero[gi] = ~|act_data_reg[15:4*gi];
    end

    always_comb begin
        cur_nib    = act_data_reg[{digit_reg, 2'b00} +: 4];
        anode_next = 4'hF;
        seg_next   = 8'hFF;
        if (enable && state_reg == DRIVE) begin
            anode_next = ~(4'b0001 << digit_reg);
            seg_next   = {~act_dp_reg[digit_reg],
                          (lz_blank && digit_reg != 2'd0 && lead_zero[digit_reg]) ?
                              7'h7F : HEX_SEG[cur_nib][6:0]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_reg   <= 8'hFF;
            anode_reg <= 4'hF;
        end else begin
            seg_reg   <= seg_next;
            anode_reg <= anode_next;
        end
    end

    assign seg   = seg_reg;
    assign anode = anode_reg;
endmodule
